// File: rtl/pulp_icache_prefetch_buffer.sv
// Sequential instruction prefetcher in front of the cluster icache fetch port.
// Issues word fetches, tags them with their address and buffers responses in order.
module pulp_icache_prefetch_buffer #(
    parameter int unsigned FetchAddrWidth = 32,
    parameter int unsigned FetchDataWidth = 32,
    parameter int unsigned FifoDepth      = 4,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      branch_i,
    input  logic [FetchAddrWidth-1:0] branch_addr_i,
    output logic                      instr_valid_o,
    input  logic                      instr_ready_i,
    output logic [FetchDataWidth-1:0] instr_rdata_o,
    output logic [FetchAddrWidth-1:0] instr_addr_o,
    output logic                      instr_err_o,
    output logic                      busy_o,
    output logic                      fetch_req_o,
    output logic [FetchAddrWidth-1:0] fetch_addr_o,
    input  logic                      fetch_gnt_i,
    input  logic                      fetch_rvalid_i,
    input  logic [FetchDataWidth-1:0] fetch_rdata_i,
    input  logic                      fetch_rerror_i
);

    localparam int unsigned CntW    = $clog2(FifoDepth + 1);
    localparam int unsigned OutW    = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW    = $clog2(FifoDepth);
    localparam int unsigned TagPtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [FetchAddrWidth-1:0] AddrInc   = FetchAddrWidth'(FetchDataWidth / 8);
    localparam logic [FetchAddrWidth-1:0] AlignMask = ~FetchAddrWidth'((FetchDataWidth / 8) - 1);

    typedef struct packed {
        logic [FetchAddrWidth-1:0] addr;
        logic [FetchDataWidth-1:0] data;
        logic                      err;
    } entry_t;

    logic [FetchAddrWidth-1:0] next_addr_q, stale_addr_q;
    logic                      active_q, hold_q, stale_q;
    logic [OutW-1:0]           out_cnt_q, out_cnt_d, discard_cnt_q;
    logic [CntW-1:0]           fifo_cnt_q;
    logic [PtrW-1:0]           rd_ptr_q, wr_ptr_q;
    logic [TagPtrW-1:0]        tag_rd_q, tag_wr_q;
    entry_t                    fifo_q [FifoDepth];
    logic [FetchAddrWidth-1:0] tag_q  [MaxOutstanding];

    logic   credit, grant, discard, accept, fifo_empty, push, pop;
    entry_t resp, head;

    function automatic logic [TagPtrW-1:0] tag_next(input logic [TagPtrW-1:0] p);
        return (32'(p) == MaxOutstanding - 1) ? '0 : p + TagPtrW'(1);
    endfunction

    // Credit counts granted-but-unanswered words against free FIFO space, so a response always has a slot.
    assign credit = active_q && (32'(out_cnt_q) < MaxOutstanding)
                  && (32'(out_cnt_q) + 32'(fifo_cnt_q) < FifoDepth);

    // A request that was raised stays up, with the same address, until it is granted.
    assign fetch_req_o  = hold_q || credit;
    assign fetch_addr_o = stale_q ? stale_addr_q : next_addr_q;
    assign grant        = fetch_req_o && fetch_gnt_i;
    assign busy_o       = fetch_req_o || (out_cnt_q != '0);

    assign discard    = branch_i || (discard_cnt_q != '0);
    assign accept     = fetch_rvalid_i && !discard;
    assign fifo_empty = (fifo_cnt_q == '0);
    assign out_cnt_d  = out_cnt_q + OutW'(grant) - OutW'(fetch_rvalid_i);

    assign resp.addr = tag_q[tag_rd_q];
    assign resp.data = fetch_rdata_i;
    assign resp.err  = fetch_rerror_i;

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        head = fifo_q[rd_ptr_q];
        if (fifo_empty) head = resp;
    end

    assign instr_valid_o = !branch_i && (!fifo_empty || accept);
    assign pop           = instr_valid_o && instr_ready_i && !fifo_empty;
    assign push          = accept && !(fifo_empty && instr_ready_i);
    assign instr_rdata_o = instr_valid_o ? head.data : '0;
    assign instr_addr_o  = instr_valid_o ? head.addr : '0;
    assign instr_err_o   = instr_valid_o && head.err;

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            next_addr_q  <= '0;
            stale_addr_q <= '0;
            active_q     <= 1'b0;
            hold_q       <= 1'b0;
            stale_q      <= 1'b0;
        end else begin
            hold_q <= fetch_req_o && !fetch_gnt_i;
            if (branch_i) begin
                active_q     <= 1'b1;
                next_addr_q  <= branch_addr_i & AlignMask;
                stale_q      <= fetch_req_o && !fetch_gnt_i;
                stale_addr_q <= fetch_addr_o;
            end else if (grant) begin
                stale_q <= 1'b0;
                if (!stale_q) next_addr_q <= next_addr_q + AddrInc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_cnt_q     <= '0;
            discard_cnt_q <= '0;
            tag_rd_q      <= '0;
            tag_wr_q      <= '0;
        end else begin
            out_cnt_q <= out_cnt_d;
            if (grant)          tag_wr_q <= tag_next(tag_wr_q);
            if (fetch_rvalid_i) tag_rd_q <= tag_next(tag_rd_q);
            // On a branch every word still owed, including this cycle's grant, is stale.
            if (branch_i) begin
                discard_cnt_q <= out_cnt_d;
            end else begin
                discard_cnt_q <= discard_cnt_q + OutW'(grant && stale_q)
                               - OutW'(fetch_rvalid_i && (discard_cnt_q != '0));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else if (branch_i) begin
            fifo_cnt_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            fifo_cnt_q <= fifo_cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // NOTE: storage arrays carry no reset; the counters and pointers alone decide which entries are live.
    always_ff @(posedge clk_i) begin
        if (push)  fifo_q[wr_ptr_q] <= resp;
        if (grant) tag_q[tag_wr_q]  <= fetch_addr_o;
    end

    a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        push |-> (fifo_cnt_q != CntW'(FifoDepth)));
    a_rvalid_has_grant: assert property (@(posedge clk_i) disable iff (!rst_ni)
        fetch_rvalid_i |-> (out_cnt_q != '0));

endmodule

// File: tb/tb_pulp_icache_prefetch_buffer.sv
// Directed bench for the prefetch buffer: a small cache responder model plus per-scenario tasks.
module tb_pulp_icache_prefetch_buffer;

    localparam logic [31:0] MAGIC = 32'hDEAD_BEEF;

    logic        clk_i, rst_ni, branch_i, instr_ready_i;
    logic [31:0] branch_addr_i, instr_rdata_o, instr_addr_o, fetch_addr_o, fetch_rdata_i;
    logic        instr_valid_o, instr_err_o, busy_o, fetch_req_o;
    logic        fetch_gnt_i, fetch_rvalid_i, fetch_rerror_i;

    int checks = 0;
    int failures = 0;

    bit          gnt_en = 1'b1;
    int          lat = 1;
    logic [31:0] err_addr = 32'hFFFF_FFFF;
    int          cyc = 0;

    typedef struct {logic [31:0] addr; int due;} pend_t;
    typedef struct {logic [31:0] addr; logic [31:0] data; logic err;} word_t;
    pend_t       pend[$];
    word_t       dlog[$];
    logic [31:0] glog[$];

    pulp_icache_prefetch_buffer dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i), .instr_rdata_o(instr_rdata_o),
        .instr_addr_o(instr_addr_o), .instr_err_o(instr_err_o), .busy_o(busy_o),
        .fetch_req_o(fetch_req_o), .fetch_addr_o(fetch_addr_o), .fetch_gnt_i(fetch_gnt_i),
        .fetch_rvalid_i(fetch_rvalid_i), .fetch_rdata_i(fetch_rdata_i), .fetch_rerror_i(fetch_rerror_i)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Cache model: drives 1 ns after each falling edge, responds in order lat cycles after grant.
    initial begin
        fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = '0; fetch_rerror_i = 1'b0;
        forever begin
            @(negedge clk_i);
            #1;
            cyc++;
            if (!rst_ni) begin
                pend.delete();
                fetch_gnt_i = 1'b0; fetch_rvalid_i = 1'b0; fetch_rdata_i = '0; fetch_rerror_i = 1'b0;
            end else begin
                fetch_gnt_i = gnt_en;
                if (pend.size() > 0 && pend[0].due <= cyc) begin
                    fetch_rvalid_i = 1'b1;
                    fetch_rdata_i  = pend[0].addr ^ MAGIC;
                    fetch_rerror_i = (pend[0].addr == err_addr);
                    void'(pend.pop_front());
                end else begin
                    fetch_rvalid_i = 1'b0; fetch_rdata_i = '0; fetch_rerror_i = 1'b0;
                end
                if (fetch_req_o && fetch_gnt_i) pend.push_back('{addr: fetch_addr_o, due: cyc + lat});
            end
        end
    end

    // Monitor: logs granted addresses and accepted words once inputs have settled.
    initial begin
        forever begin
            @(negedge clk_i);
            #3;
            if (rst_ni) begin
                if (fetch_req_o && fetch_gnt_i) glog.push_back(fetch_addr_o);
                if (instr_valid_o && instr_ready_i)
                    dlog.push_back('{addr: instr_addr_o, data: instr_rdata_o, err: instr_err_o});
            end
        end
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic apply_reset();
        @(negedge clk_i);
        rst_ni = 1'b0; branch_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        glog.delete(); dlog.delete();
    endtask

    task automatic start_branch(input logic [31:0] addr);
        @(negedge clk_i);
        branch_i = 1'b1; branch_addr_i = addr;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        #2;
        checks++; if (fetch_req_o !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", fetch_req_o); end
        checks++; if (fetch_addr_o !== 32'h0) begin failures++; $display("FAIL reset_fetch_addr: got %h want 0", fetch_addr_o); end
        checks++; if ({instr_valid_o, instr_err_o, busy_o} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {instr_valid_o, instr_err_o, busy_o}); end
        checks++; if ({instr_rdata_o, instr_addr_o} !== 64'h0) begin failures++; $display("FAIL reset_instr: got %h want 0", {instr_rdata_o, instr_addr_o}); end
        repeat (3) @(negedge clk_i);
        #2;
        checks++; if ({fetch_req_o, busy_o} !== 2'b00) begin failures++; $display("FAIL idle_before_branch: got %b want 00", {fetch_req_o, busy_o}); end
    endtask

    task automatic test_sequential();
        apply_reset();
        instr_ready_i = 1'b1; gnt_en = 1'b1; lat = 1;
        start_branch(32'h1000);
        #2;
        checks++; if (fetch_req_o !== 1'b0) begin failures++; $display("FAIL seq_branch_cycle_req: got %b want 0", fetch_req_o); end
        @(negedge clk_i); branch_i = 1'b0; #2;
        checks++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h1000) begin failures++; $display("FAIL seq_first_req: got %b/%h want 1/00001000", fetch_req_o, fetch_addr_o); end
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL seq_valid_early: got %b want 0", instr_valid_o); end
        @(negedge clk_i); #2;
        checks++; if (instr_valid_o !== 1'b1 || instr_addr_o !== 32'h1000) begin failures++; $display("FAIL seq_fallthrough: got %b/%h want 1/00001000", instr_valid_o, instr_addr_o); end
        checks++; if (instr_rdata_o !== (32'h1000 ^ MAGIC)) begin failures++; $display("FAIL seq_fallthrough_data: got %h want %h", instr_rdata_o, 32'h1000 ^ MAGIC); end
        checks++; if (fetch_addr_o !== 32'h1004) begin failures++; $display("FAIL seq_second_req: got %h want 00001004", fetch_addr_o); end
        repeat (6) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ea;
            ea = 32'h1000 + 32'(4 * i);
            checks++; if (i >= glog.size() || glog[i] !== ea) begin failures++; $display("FAIL seq_grant_order[%0d]: got %h want %h", i, (i < glog.size()) ? glog[i] : 32'hx, ea); end
            checks++; if (i >= dlog.size() || dlog[i].addr !== ea || dlog[i].data !== (ea ^ MAGIC)) begin failures++; $display("FAIL seq_deliver[%0d]: want addr %h", i, ea); end
        end
    endtask

    task automatic test_fifo_full();
        apply_reset();
        instr_ready_i = 1'b0; gnt_en = 1'b1; lat = 1;
        start_branch(32'h1000);
        @(negedge clk_i); branch_i = 1'b0;
        repeat (7) @(negedge clk_i);
        #2;
        checks++; if (glog.size() != 4) begin failures++; $display("FAIL full_grant_count: got %0d want 4", glog.size()); end
        checks++; if ({fetch_req_o, busy_o} !== 2'b00) begin failures++; $display("FAIL full_req_dropped: got %b want 00", {fetch_req_o, busy_o}); end
        checks++; if (instr_valid_o !== 1'b1 || instr_addr_o !== 32'h1000) begin failures++; $display("FAIL full_head: got %b/%h want 1/00001000", instr_valid_o, instr_addr_o); end
        checks++; if (dlog.size() != 0) begin failures++; $display("FAIL full_no_accept: got %0d want 0", dlog.size()); end
        instr_ready_i = 1'b1;
        repeat (8) @(negedge clk_i);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] ea;
            ea = 32'h1000 + 32'(4 * i);
            checks++; if (i >= dlog.size() || dlog[i].addr !== ea || dlog[i].data !== (ea ^ MAGIC)) begin failures++; $display("FAIL full_drain[%0d]: want addr %h", i, ea); end
        end
        checks++; if (glog.size() < 5 || glog[4] !== 32'h1010) begin failures++; $display("FAIL full_resume: got %h want 00001010", (glog.size() > 4) ? glog[4] : 32'hx); end
    endtask

    task automatic test_branch_outstanding();
        apply_reset();
        instr_ready_i = 1'b1; gnt_en = 1'b1; lat = 3;
        start_branch(32'h1000);
        @(negedge clk_i); branch_i = 1'b0;
        @(negedge clk_i);
        start_branch(32'h2003);
        #2;
        checks++; if ({fetch_req_o, busy_o} !== 2'b01) begin failures++; $display("FAIL bro_two_outstanding: got %b want 01", {fetch_req_o, busy_o}); end
        @(negedge clk_i); branch_i = 1'b0; #2;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL bro_drop_first: got %b want 0", instr_valid_o); end
        @(negedge clk_i); #2;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL bro_drop_second: got %b want 0", instr_valid_o); end
        checks++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h2000) begin failures++; $display("FAIL bro_new_req: got %b/%h want 1/00002000", fetch_req_o, fetch_addr_o); end
        repeat (3) @(negedge clk_i); #2;
        checks++; if (instr_valid_o !== 1'b1 || instr_addr_o !== 32'h2000) begin failures++; $display("FAIL bro_first_word: got %b/%h want 1/00002000", instr_valid_o, instr_addr_o); end
        repeat (4) @(negedge clk_i);
        checks++; if (dlog.size() < 2 || dlog[0].addr !== 32'h2000 || dlog[1].addr !== 32'h2004) begin failures++; $display("FAIL bro_deliver: got %0d words, first %h want 00002000,00002004", dlog.size(), (dlog.size() > 0) ? dlog[0].addr : 32'hx); end
        checks++; if (glog.size() < 3 || glog[2] !== 32'h2000) begin failures++; $display("FAIL bro_grants: got %h want 00002000", (glog.size() > 2) ? glog[2] : 32'hx); end
        lat = 1;
    endtask

    task automatic test_branch_pending();
        apply_reset();
        instr_ready_i = 1'b1; gnt_en = 1'b0; lat = 1;
        start_branch(32'h1000);
        start_branch(32'h2000);
        #2;
        checks++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h1000) begin failures++; $display("FAIL pend_at_branch: got %b/%h want 1/00001000", fetch_req_o, fetch_addr_o); end
        @(negedge clk_i); branch_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            checks++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h1000) begin failures++; $display("FAIL pend_stable[%0d]: got %b/%h want 1/00001000", i, fetch_req_o, fetch_addr_o); end
            @(negedge clk_i);
            if (i == 1) gnt_en = 1'b1;
        end
        #2;
        checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL pend_dropped: got %b want 0", instr_valid_o); end
        checks++; if (fetch_req_o !== 1'b1 || fetch_addr_o !== 32'h2000) begin failures++; $display("FAIL pend_next_req: got %b/%h want 1/00002000", fetch_req_o, fetch_addr_o); end
        @(negedge clk_i); #2;
        checks++; if (instr_valid_o !== 1'b1 || instr_addr_o !== 32'h2000) begin failures++; $display("FAIL pend_first_word: got %b/%h want 1/00002000", instr_valid_o, instr_addr_o); end
        checks++; if (glog.size() < 2 || glog[0] !== 32'h1000 || glog[1] !== 32'h2000) begin failures++; $display("FAIL pend_grants: got %0d grants want 00001000,00002000", glog.size()); end
        gnt_en = 1'b1;
    endtask

    task automatic test_error();
        apply_reset();
        instr_ready_i = 1'b1; gnt_en = 1'b1; lat = 1; err_addr = 32'h1004;
        start_branch(32'h1000);
        @(negedge clk_i); branch_i = 1'b0;
        repeat (6) @(negedge clk_i);
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ea;
            ea = 32'h1000 + 32'(4 * i);
            checks++; if (i >= dlog.size() || dlog[i].addr !== ea || dlog[i].err !== (i == 1)) begin failures++; $display("FAIL err_word[%0d]: got err %b want %b at %h", i, (i < dlog.size()) ? dlog[i].err : 1'bx, (i == 1), ea); end
        end
        err_addr = 32'hFFFF_FFFF;
    endtask

    task automatic test_wrap_and_reset();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
        apply_reset();
        instr_ready_i = 1'b1; gnt_en = 1'b1; lat = 1;
        start_branch(32'hFFFF_FFF8);
        @(negedge clk_i); branch_i = 1'b0;
        repeat (6) @(negedge clk_i);
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= glog.size() || glog[i] !== exp_addr[i]) begin failures++; $display("FAIL wrap_grant[%0d]: got %h want %h", i, (i < glog.size()) ? glog[i] : 32'hx, exp_addr[i]); end
            checks++; if (i >= dlog.size() || dlog[i].addr !== exp_addr[i]) begin failures++; $display("FAIL wrap_deliver[%0d]: want %h", i, exp_addr[i]); end
        end
        #2;
        checks++; if ({fetch_req_o, busy_o} !== 2'b11) begin failures++; $display("FAIL pre_reset_active: got %b want 11", {fetch_req_o, busy_o}); end
        @(negedge clk_i);
        rst_ni = 1'b0;
        #2;
        checks++; if ({fetch_req_o, busy_o, instr_valid_o, instr_err_o} !== 4'b0000) begin failures++; $display("FAIL async_reset_flags: got %b want 0000", {fetch_req_o, busy_o, instr_valid_o, instr_err_o}); end
        checks++; if ({fetch_addr_o, instr_addr_o, instr_rdata_o} !== 96'h0) begin failures++; $display("FAIL async_reset_data: got %h want 0", {fetch_addr_o, instr_addr_o, instr_rdata_o}); end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i); #2;
        checks++; if ({fetch_req_o, busy_o} !== 2'b00) begin failures++; $display("FAIL post_reset_idle: got %b want 00", {fetch_req_o, busy_o}); end
    endtask

    initial begin
        rst_ni = 1'b1; branch_i = 1'b0; branch_addr_i = '0; instr_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        test_reset();
        test_sequential();
        test_fifo_full();
        test_branch_outstanding();
        test_branch_pending();
        test_error();
        test_wrap_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
